// File: rtl/sum_stream_checker.sv
// -----------------------------------------------------------------------------
// sum_stream_checker
//
// Consumer end of the counter-sum stream. The block accepts WIDTH-bit words
// over a valid/ready handshake and checks that each accepted word is the
// previous one plus STEP (mod 2^WIDTH). It seeds itself from the first word it
// accepts and declares lock after LOCK_COUNT consecutive matching words,
// counting the seed. While locked it free-runs its own expectation, so one
// corrupted word costs a single error. After LOSS_COUNT consecutive misses it
// drops lock and reseeds from the next word it accepts.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   checker can accept (= !hold while out of reset)
//   in_data    upstream word
//   hold       backpressure request, forces in_ready low
//   clear      synchronous clear of err_count / word_count (wins over accept)
//   locked     high while in LOCKED or SLIP
//   err_pulse  one-cycle pulse per mismatching word while locked
//   err_count  saturating mismatch count
//   word_count saturating count of accepted words
//   expected   value the next accepted word must equal
// -----------------------------------------------------------------------------
module sum_stream_checker #(
   parameter int WIDTH      = 8,
   parameter int STEP       = 2,
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             hold,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] word_count,
   output logic [WIDTH-1:0] expected
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int SW = $clog2(LOSS_COUNT + 1);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam logic [MW-1:0]    LOCK_N = MW'(LOCK_COUNT);
   localparam logic [SW-1:0]    LOSS_N = SW'(LOSS_COUNT);

   // The two locked states share state[1] = 1, so the locked output is a
   // straight flop output rather than a decode of several state bits.
   typedef enum logic [1:0] {
      SEARCH  = 2'b00,
      LOCKING = 2'b01,
      LOCKED  = 2'b10,
      SLIP    = 2'b11
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] expected_nx;
   logic [MW-1:0]    match_cnt, match_nx;
   logic [SW-1:0]    miss_cnt, miss_nx;
   logic             err_nx;
   logic [CNT_W-1:0] err_count_nx, word_count_nx;
   logic             accept;
   logic             hit;

   // Saturating increment for the statistics counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   assign in_ready = reset_n & ~hold;
   assign accept   = in_valid & in_ready;
   assign hit      = (in_data == expected);
   assign locked   = state[1];

   always_comb begin
      state_nx      = state;
      expected_nx   = expected;
      match_nx      = match_cnt;
      miss_nx       = miss_cnt;
      err_nx        = 1'b0;
      err_count_nx  = err_count;
      word_count_nx = word_count;

      if (accept) begin
         word_count_nx = sat_inc(word_count);
         unique case (state)
            SEARCH: begin
               expected_nx = in_data + STEP_W;
               match_nx    = MW'(1);
               state_nx    = LOCKING;
            end
            LOCKING: begin
               // Before lock the expectation tracks the data, so any
               // mismatching word simply becomes the new seed.
               expected_nx = in_data + STEP_W;
               miss_nx     = '0;
               if (hit) begin
                  match_nx = match_cnt + MW'(1);
                  if (match_nx == LOCK_N) state_nx = LOCKED;
               end else begin
                  match_nx = MW'(1);
               end
            end
            LOCKED: begin
               // Once locked the expectation free-runs, so an isolated bad
               // word does not drag the reference along with it.
               expected_nx = expected + STEP_W;
               if (!hit) begin
                  err_nx       = 1'b1;
                  err_count_nx = sat_inc(err_count);
                  miss_nx      = SW'(1);
                  state_nx     = (LOSS_COUNT == 1) ? SEARCH : SLIP;
               end
            end
            SLIP: begin
               expected_nx = expected + STEP_W;
               if (hit) begin
                  miss_nx  = '0;
                  state_nx = LOCKED;
               end else begin
                  err_nx       = 1'b1;
                  err_count_nx = sat_inc(err_count);
                  miss_nx      = miss_cnt + SW'(1);
                  if (miss_nx == LOSS_N) state_nx = SEARCH;
               end
            end
            default: state_nx = SEARCH;
         endcase
      end

      // clear wins over a same-cycle accept; the word is not counted.
      if (clear) begin
         err_count_nx  = '0;
         word_count_nx = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SEARCH;
         expected   <= '0;
         match_cnt  <= '0;
         miss_cnt   <= '0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
      end else begin
         state      <= state_nx;
         expected   <= expected_nx;
         match_cnt  <= match_nx;
         miss_cnt   <= miss_nx;
         err_pulse  <= err_nx;
         err_count  <= err_count_nx;
         word_count <= word_count_nx;
      end
   end

endmodule

// File: tb/tb_sum_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_sum_stream_checker
//
// Self-checking bench for sum_stream_checker: directed scenarios (reset, lock,
// wrap, single corruption, loss/reseed, gaps, clear, mid-run reset) followed
// by randomized traffic, all compared against a behavioural model of the
// lock/track rules. Counters are built narrow so saturation is reached.
// -----------------------------------------------------------------------------
module tb_sum_stream_checker;

   localparam int W    = 8;
   localparam int STEP = 2;
   localparam int LC   = 4;
   localparam int LS   = 3;
   localparam int CW   = 6;
   localparam int MOD  = 1 << W;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          hold = 1'b0;
   logic          clear = 1'b0;
   logic          locked;
   logic          err_pulse;
   logic [CW-1:0] err_count;
   logic [CW-1:0] word_count;
   logic [W-1:0]  expected;

   sum_stream_checker #(
      .WIDTH(W), .STEP(STEP), .LOCK_COUNT(LC), .LOSS_COUNT(LS), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .hold(hold), .clear(clear), .locked(locked),
      .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count),
      .expected(expected)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: "seeded" means a first word has been taken,
   // "run" is the current streak of consecutive matches, "miss" the streak
   // of misses while locked.
   int m_seeded, m_lock, m_run, m_miss, m_exp, m_err, m_words, m_pulse;

   task automatic chk(input string tag, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic void model_reset();
      m_seeded = 0; m_lock = 0; m_run = 0; m_miss = 0;
      m_exp = 0; m_err = 0; m_words = 0; m_pulse = 0;
   endfunction

   function automatic void model_step(input bit acc, input int d, input bit c);
      m_pulse = 0;
      if (acc) begin
         m_words = (m_words < CMAX) ? m_words + 1 : CMAX;
         if (!m_seeded) begin
            m_seeded = 1;
            m_run    = 1;
            m_exp    = (d + STEP) % MOD;
         end else if (!m_lock) begin
            m_run = (d == m_exp) ? m_run + 1 : 1;
            m_exp = (d + STEP) % MOD;
            if (m_run == LC) begin
               m_lock = 1;
               m_miss = 0;
            end
         end else begin
            if (d == m_exp) begin
               m_miss = 0;
            end else begin
               m_pulse = 1;
               m_err   = (m_err < CMAX) ? m_err + 1 : CMAX;
               m_miss++;
               if (m_miss == LS) begin
                  m_lock   = 0;
                  m_seeded = 0;
                  m_miss   = 0;
               end
            end
            m_exp = (m_exp + STEP) % MOD;
         end
      end
      if (c) begin
         m_words = 0;
         m_err   = 0;
      end
   endfunction

   task automatic check_outputs();
      chk("locked", locked, m_lock);
      chk("err_pulse", err_pulse, m_pulse);
      chk("err_count", err_count, m_err);
      chk("word_count", word_count, m_words);
      chk("expected", expected, m_exp);
   endtask

   // One clock cycle: drive inputs, clock the DUT and the model, then check
   // on the falling edge.
   task automatic step(input bit v, input int d, input bit h, input bit c);
      bit acc;
      in_valid = v;
      in_data  = W'(d);
      hold     = h;
      clear    = c;
      #1;
      chk("in_ready", in_ready, (reset_n && !h) ? 1 : 0);
      @(posedge clk);
      acc = v && !h && reset_n;
      model_step(acc, d % MOD, c);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send(input int d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      hold     = 1'b0;
      clear    = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("in_ready_in_reset", in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      reset_n = 1'b1;
      #1;
      chk("in_ready_after_reset", in_ready, 1);
   endtask

   initial begin
      int gen;
      model_reset();

      // Reset, then hold blocks acceptance despite in_valid.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 5, 1'b1, 1'b0);
      chk("hold_words", word_count, 0);

      // Lock on 0,2,4,6.
      send(0); send(2); send(4);
      chk("prelock_locked", locked, 0);
      send(6);
      chk("lock_locked", locked, 1);
      chk("lock_expected", expected, 8);
      chk("lock_words", word_count, 4);
      chk("lock_errs", err_count, 0);

      // Isolated corruption.
      send(8); send(10); send(99);
      chk("corr_pulse", err_pulse, 1);
      chk("corr_locked", locked, 1);
      send(14);
      chk("corr_locked_after", locked, 1);
      chk("corr_errs", err_count, 1);
      chk("corr_expected", expected, 16);

      // Loss and reseed.
      send(16); send(18);
      send(77); send(78); send(79);
      chk("loss_locked", locked, 0);
      chk("loss_errs", err_count, 4);
      send(40); send(42); send(44); send(46);
      chk("relock_locked", locked, 1);
      chk("relock_expected", expected, 48);

      // Lose again, relock just below the wrap point, then cross it.
      send(1); send(1); send(1);
      send(242); send(244); send(246); send(248);
      chk("prewrap_expected", expected, 250);
      send(250); send(252); send(254); send(0); send(2);
      chk("wrap_expected", expected, 4);
      chk("wrap_locked", locked, 1);
      chk("wrap_errs", err_count, 7);

      // Clear together with an accept.
      step(1'b1, 4, 1'b0, 1'b1);
      chk("clear_words", word_count, 0);
      chk("clear_expected", expected, 6);

      // Reset while locked, then lock through gaps and hold toggling.
      do_reset();
      step(1'b1, 0, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      step(1'b1, 2, 1'b1, 1'b0);
      step(1'b1, 2, 1'b0, 1'b0);
      step(1'b0, 9, 1'b1, 1'b0);
      step(1'b1, 4, 1'b0, 1'b0);
      step(1'b1, 6, 1'b1, 1'b0);
      step(1'b1, 6, 1'b0, 1'b0);
      chk("gap_locked", locked, 1);
      chk("gap_expected", expected, 8);
      chk("gap_words", word_count, 4);

      // Randomized traffic: mostly a clean sum stream with corrupted words,
      // stream jumps, gaps, backpressure, rare clears and resets.
      gen = 8;
      for (int i = 0; i < 3000; i++) begin
         bit v, h, c;
         int r, d;
         v = ($urandom_range(0, 3) != 0);
         h = ($urandom_range(0, 4) == 0);
         c = ($urandom_range(0, 199) == 0);
         r = $urandom_range(0, 99);
         if (r < 85) begin
            d = gen;
         end else if (r < 95) begin
            d = int'($urandom_range(0, MOD - 1));
         end else begin
            gen = int'($urandom_range(0, MOD - 1));
            d   = gen;
         end
         step(v, d, h, c);
         if (v && !h) gen = (gen + STEP) % MOD;
         if ($urandom_range(0, 999) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
